// File: rtl/redux_pkg.sv
// Shared types and constants for the redux_seq control sequencer.
package redux_pkg;

   // Sequencer states; one cycle each except MEM, which lasts MEM_LAT cycles.
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } redux_seq_state_t;

   // Opcode that stops the core until resume is pulsed.
   localparam logic [3:0] HALT_OP_DEFAULT = 4'b1111;

endpackage

// File: rtl/redux_lat_cnt.sv
// Memory-latency down counter: loaded on MEM entry, decremented each MEM
// cycle, flags zero so the sequencer knows the access has completed.
module redux_lat_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] count,
   output logic       zero
);

   // Load takes priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   // Zero flag is decoded straight from the count register.
   always_comb begin
      zero = (count == 4'd0);
   end

endmodule

// File: rtl/redux_seq.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// with a HALT state left only by a resume pulse.
// Optional single-step gating of FETCH is built when REDUX_SEQ_STEP_EN is
// defined (adds step_mode/step inputs).
//
// Strobes are decoded from the current state and masked while rst is high,
// so no write can commit in the cycle a reset aborts an instruction.
module redux_seq
   import redux_pkg::*;
#(
   parameter int         MEM_LAT = 1,
   parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  opcode,
   input  logic        ctl_re,
   input  logic        ctl_we,
   input  logic        ctl_dmx,
   input  logic        resume,
`ifdef REDUX_SEQ_STEP_EN
   input  logic        step_mode,
   input  logic        step,
`endif
   output logic        ir_en,
   output logic        pc_en,
   output logic        rf_we,
   output logic        dm_we,
   output logic        halted,
   output logic [15:0] instr_cnt
);

   // Value loaded into the latency counter on MEM entry; it also marks the
   // first MEM cycle, since the count only ever moves down from here.
   localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

   redux_seq_state_t state;
   redux_seq_state_t next_state;

   logic       ir_raw;
   logic       pc_raw;
   logic       rf_raw;
   logic       dm_raw;
   logic       fetch_go;
   logic       mem_load;
   logic       mem_dec;
   logic       retire;
   logic [3:0] mem_count;
   logic       mem_zero;

   redux_lat_cnt u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (mem_load),
      .load_val (MEM_LOAD),
      .dec      (mem_dec),
      .count    (mem_count),
      .zero     (mem_zero)
   );

   // FETCH may be held off by single-step mode; otherwise it always proceeds.
   always_comb begin
`ifdef REDUX_SEQ_STEP_EN
      fetch_go = !step_mode || step;
`else
      fetch_go = 1'b1;
`endif
   end

   // State register; reset wins over every transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      next_state = state;
      ir_raw     = 1'b0;
      pc_raw     = 1'b0;
      rf_raw     = 1'b0;
      dm_raw     = 1'b0;
      halted     = 1'b0;
      mem_load   = 1'b0;
      mem_dec    = 1'b0;
      retire     = 1'b0;
      case (state)
         S_FETCH: begin
            if (fetch_go) begin
               ir_raw     = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            next_state = S_EXEC;
         end
         S_EXEC: begin
            if (opcode == HALT_OP) begin
               next_state = S_HALT;
            end else if (ctl_we || (ctl_re && !ctl_dmx)) begin
               next_state = S_MEM;
               mem_load   = 1'b1;
            end else begin
               next_state = S_WB;
            end
         end
         S_MEM: begin
            // A store writes memory once, on the first MEM cycle only.
            dm_raw = ctl_we && (mem_count == MEM_LOAD);
            if (mem_zero) begin
               next_state = S_WB;
            end else begin
               mem_dec = 1'b1;
            end
         end
         S_WB: begin
            pc_raw     = 1'b1;
            rf_raw     = ctl_re;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (resume) begin
               pc_raw     = 1'b1;
               next_state = S_FETCH;
            end
         end
         default: begin
            next_state = S_FETCH;
         end
      endcase
   end

   // Strobes are suppressed while reset is asserted.
   always_comb begin
      ir_en = ir_raw && !rst;
      pc_en = pc_raw && !rst;
      rf_we = rf_raw && !rst;
      dm_we = dm_raw && !rst;
   end

   // Retired-instruction counter; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_cnt <= 16'd0;
      end else if (retire) begin
         instr_cnt <= instr_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_redux_seq.sv
// Bench for redux_seq (MEM_LAT = 3). Per-cycle strobe words
// {ir_en, pc_en, rf_we, dm_we, halted} are queued when an instruction is
// driven and compared cycle by cycle as the DUT steps through it.
module tb_redux_seq;

   localparam int         MEM_LAT = 3;
   localparam logic [3:0] HALT_OP = 4'b1111;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  opcode;
   logic        ctl_re;
   logic        ctl_we;
   logic        ctl_dmx;
   logic        resume;
`ifdef REDUX_SEQ_STEP_EN
   logic        step_mode;
   logic        step;
`endif
   logic        ir_en;
   logic        pc_en;
   logic        rf_we;
   logic        dm_we;
   logic        halted;
   logic [15:0] instr_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_cnt;
   logic [4:0]  exp_q[$];

   redux_seq #(
      .MEM_LAT (MEM_LAT),
      .HALT_OP (HALT_OP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .ctl_re    (ctl_re),
      .ctl_we    (ctl_we),
      .ctl_dmx   (ctl_dmx),
      .resume    (resume),
`ifdef REDUX_SEQ_STEP_EN
      .step_mode (step_mode),
      .step      (step),
`endif
      .ir_en     (ir_en),
      .pc_en     (pc_en),
      .rf_we     (rf_we),
      .dm_we     (dm_we),
      .halted    (halted),
      .instr_cnt (instr_cnt)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] strobes();
      return {ir_en, pc_en, rf_we, dm_we, halted};
   endfunction

   // Pop one expected word per cycle, compare at the falling edge, then
   // return 1 time unit after the next rising edge.
   task automatic drain(input string tag);
      logic [4:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         check_eq(tag, {11'd0, strobes()}, {11'd0, e});
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the expected trace of one non-halt instruction, starting in FETCH.
   task automatic push_instr(input logic re, input logic we, input logic dmx);
      exp_q.push_back(5'b10000);
      exp_q.push_back(5'b00000);
      exp_q.push_back(5'b00000);
      if (we || (re && !dmx)) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            exp_q.push_back((i == 0) ? {3'b000, we, 1'b0} : 5'b00000);
         end
      end
      exp_q.push_back({1'b0, 1'b1, re, 2'b00});
   endtask

   // Drive and check a full instruction; resume is held at res throughout.
   task automatic run_instr(input string tag, input logic [3:0] op, input logic re,
                            input logic we, input logic dmx, input logic res);
      opcode  = op;
      ctl_re  = re;
      ctl_we  = we;
      ctl_dmx = dmx;
      resume  = res;
      push_instr(re, we, dmx);
      drain(tag);
      resume  = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      check_eq({tag, "_cnt"}, instr_cnt, exp_cnt);
   endtask

   initial begin
      rst     = 1'b1;
      opcode  = 4'd0;
      ctl_re  = 1'b0;
      ctl_we  = 1'b0;
      ctl_dmx = 1'b0;
      resume  = 1'b0;
      exp_cnt = 16'd0;
`ifdef REDUX_SEQ_STEP_EN
      step_mode = 1'b0;
      step      = 1'b0;
`endif

      // Reset: strobes low and counter cleared while rst is held.
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("rst_strobes", {11'd0, strobes()}, 16'd0);
      check_eq("rst_cnt", instr_cnt, 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ALU op writing a register: ir_en cycle 1, rf_we+pc_en cycle 4.
      run_instr("alu", 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
      // Store with MEM_LAT=3: one dm_we, pc_en on cycle 7, no rf_we.
      run_instr("store", 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
      // Load: goes through MEM, writes register in WB.
      run_instr("load", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
      // Branch-like op with no writes; resume held high must be ignored.
      run_instr("branch_res", 4'h4, 1'b0, 1'b0, 1'b1, 1'b1);

      // HALT: halted from cycle 4, ten quiet cycles, then resume pulse.
      opcode = HALT_OP;
      ctl_re = 1'b1;
      ctl_we = 1'b1;
      resume = 1'b0;
      exp_q.push_back(5'b10000);
      exp_q.push_back(5'b00000);
      exp_q.push_back(5'b00000);
      for (int i = 0; i < 10; i++) exp_q.push_back(5'b00001);
      drain("halt");
      resume = 1'b1;
      exp_q.push_back(5'b01001);
      drain("resume");
      resume = 1'b0;
      check_eq("halt_cnt", instr_cnt, exp_cnt);
      // FETCH must follow immediately after the resume cycle.
      run_instr("post_halt", 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of a load's MEM phase.
      opcode  = 4'h6;
      ctl_re  = 1'b1;
      ctl_we  = 1'b0;
      ctl_dmx = 1'b0;
      exp_q.push_back(5'b10000);
      exp_q.push_back(5'b00000);
      exp_q.push_back(5'b00000);
      exp_q.push_back(5'b00000);
      drain("pre_abort");
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_strobes", {11'd0, strobes()}, 16'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      exp_cnt = 16'd0;
      check_eq("abort_cnt", instr_cnt, 16'd0);
      run_instr("after_abort", 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);

      // Random mix of non-halt instructions.
      for (int i = 0; i < 20; i++) begin
         run_instr("rand", 4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end

      // Counter wrap: start the counter at FFFF, retire one instruction.
      force dut.instr_cnt = 16'hFFFF;
      #1;
      release dut.instr_cnt;
      #1;
      exp_cnt = 16'hFFFF;
      check_eq("preload_cnt", instr_cnt, 16'hFFFF);
      run_instr("wrap", 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef REDUX_SEQ_STEP_EN
      // Single-step: FETCH holds until step, then the instruction runs.
      step_mode = 1'b1;
      step      = 1'b0;
      opcode    = 4'h1;
      ctl_re    = 1'b1;
      ctl_we    = 1'b0;
      ctl_dmx   = 1'b1;
      for (int i = 0; i < 5; i++) exp_q.push_back(5'b00000);
      drain("step_hold");
      step = 1'b1;
      exp_q.push_back(5'b10000);
      drain("step_go");
      step = 1'b0;
      exp_q.push_back(5'b00000);
      exp_q.push_back(5'b00000);
      exp_q.push_back(5'b01100);
      drain("step_run");
      exp_cnt = exp_cnt + 16'd1;
      check_eq("step_cnt", instr_cnt, exp_cnt);
      step_mode = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
